// File: rtl/tb4004_pkg.sv
// Shared definitions for the TB4004 fetch front end: PC operation codes and
// the names of the eight sub-cycles of a standard machine cycle.
package tb4004_pkg;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b01;
    localparam logic [1:0] PC_CALL = 2'b10;
    localparam logic [1:0] PC_RET  = 2'b11;

    // Sub-cycle names for the 8-clock machine cycle (NCYC = 8).
    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } cycleName_e;

endpackage

// File: rtl/call_stack.sv
// Circular return-address stack with a write pointer (4004 semantics):
// overflow overwrites the oldest entry, underflow returns a stale entry.
module call_stack
    import tb4004_pkg::*;
#(
    parameter  int ADDR_W = 12,
    parameter  int DEPTH  = 3,
    localparam int SP_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic [SP_W-1:0]   sp,
    output logic              ovf,
    output logic              unf
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [SP_W-1:0]  FULL  = SP_W'(DEPTH);

    logic [ADDR_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  nextPtr;
    logic [PTR_W-1:0]  prevPtr;

    assign nextPtr = (wrPtr == LAST) ? '0 : wrPtr + PTR_W'(1);
    assign prevPtr = (wrPtr == '0) ? LAST : wrPtr - PTR_W'(1);

    // The top of stack is always the slot just below the write pointer.
    assign dout = entries[prevPtr];
    assign ovf  = push && (sp == FULL);
    assign unf  = pop && (sp == '0);

    // NOTE: the entry storage carries no reset; only the pointer and the
    // occupancy count need a known value, so the RAM stays a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wrPtr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            sp    <= '0;
        end else if (push) begin
            wrPtr <= nextPtr;
            if (sp != FULL) begin
                sp <= sp + SP_W'(1);
            end
        end else if (pop) begin
            wrPtr <= prevPtr;
            if (sp != '0) begin
                sp <= sp - SP_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// TB4004 instruction-fetch front end: machine-cycle timing, program counter,
// OPR/OPA and second-word latching, and the return stack with sticky flags.
module fetch_sequencer
    import tb4004_pkg::*;
#(
    parameter  int                ADDR_W   = 12,
    parameter  int                DATA_W   = 4,
    parameter  int                NCYC     = 8,
    parameter  int                M1_CYC   = 3,
    parameter  int                M2_CYC   = 4,
    parameter  int                DEPTH    = 3,
    parameter  logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int                CYC_W    = $clog2(NCYC),
    localparam int                SP_W     = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [DATA_W-1:0]   romData,
    input  logic                twoWord,
    input  logic [1:0]          pcOp,
    input  logic [ADDR_W-1:0]   pcNew,
    input  logic                clrFlags,
    output logic [CYC_W-1:0]    cycle,
    output logic                sync,
    output logic [ADDR_W-1:0]   pcAddr,
    output logic [DATA_W-1:0]   opr,
    output logic [DATA_W-1:0]   opa,
    output logic [2*DATA_W-1:0] arg,
    output logic                secondWord,
    output logic                instrValid,
    output logic [SP_W-1:0]     sp,
    output logic                stackOverflow,
    output logic                stackUnderflow
);

    localparam logic [CYC_W-1:0] CYC_M1   = CYC_W'(M1_CYC);
    localparam logic [CYC_W-1:0] CYC_M2   = CYC_W'(M2_CYC);
    localparam logic [CYC_W-1:0] CYC_DEC  = CYC_W'(M2_CYC + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(NCYC - 1);

    logic              twoWordLat;
    logic              pcWrap;
    logic              takeSecond;
    logic              doPush;
    logic              doPop;
    logic [ADDR_W-1:0] pcInc;
    logic [ADDR_W-1:0] stackTop;
    logic              stkOvf;
    logic              stkUnf;

    assign pcWrap     = (cycle == CYC_LAST);
    assign takeSecond = !secondWord && twoWordLat;
    assign pcInc      = pcAddr + ADDR_W'(1);
    assign doPush     = pcWrap && !takeSecond && (pcOp == PC_CALL);
    assign doPop      = pcWrap && !takeSecond && (pcOp == PC_RET);

    assign sync = (cycle == '0);

    // The decoder answers twoWord combinationally from the freshly latched
    // OPR/OPA, so validity is only known during the decode sub-cycle itself.
    assign instrValid = (cycle == CYC_DEC) && (secondWord || !twoWord);

    call_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) uStack (
        .clk  (clk),
        .rstN (rstN),
        .push (doPush),
        .pop  (doPop),
        .din  (pcInc),
        .dout (stackTop),
        .sp   (sp),
        .ovf  (stkOvf),
        .unf  (stkUnf)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cycle          <= '0;
            pcAddr         <= RESET_PC;
            opr            <= '0;
            opa            <= '0;
            arg            <= '0;
            secondWord     <= 1'b0;
            twoWordLat     <= 1'b0;
            stackOverflow  <= 1'b0;
            stackUnderflow <= 1'b0;
        end else begin
            cycle <= pcWrap ? '0 : cycle + CYC_W'(1);

            if (cycle == CYC_M1) begin
                if (secondWord) begin
                    arg[2*DATA_W-1:DATA_W] <= romData;
                end else begin
                    opr <= romData;
                end
            end

            if (cycle == CYC_M2) begin
                if (secondWord) begin
                    arg[DATA_W-1:0] <= romData;
                end else begin
                    opa <= romData;
                end
            end

            if ((cycle == CYC_DEC) && !secondWord) begin
                twoWordLat <= twoWord;
            end

            // A pending second word takes priority over whatever pcOp says.
            if (pcWrap) begin
                if (takeSecond) begin
                    pcAddr     <= pcInc;
                    secondWord <= 1'b1;
                end else begin
                    secondWord <= 1'b0;
                    case (pcOp)
                        PC_JUMP, PC_CALL: pcAddr <= pcNew;
                        PC_RET:           pcAddr <= stackTop;
                        default:          pcAddr <= pcInc;
                    endcase
                end
            end

            stackOverflow  <= stkOvf | (stackOverflow & ~clrFlags);
            stackUnderflow <= stkUnf | (stackUnderflow & ~clrFlags);
        end
    end

endmodule
